// File: rtl/line_double_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : line_double_buffer_if
// Description : Bundles the timing-generator inputs, the renderer write port
//               and the display/handshake outputs of line_double_buffer.
//               master : timing generator + renderer side (drives hc/vc/vbl,
//                        wr_*; observes line_start/render_line/init_done/pix)
//               slave  : line_double_buffer itself
// Ports       : hc, vc, vbl            - raster position and vertical blank
//               wr_en, wr_x, wr_data   - renderer pixel write
//               line_start, render_line- next-line handshake to renderer
//               init_done              - post-reset clear sweep finished
//               pix, pix_valid         - display pixel stream
// Revision    : 1.0 - initial release
// ============================================================================
interface line_double_buffer_if #(
  parameter int DW = 8
);
  logic [8:0]    hc;
  logic [8:0]    vc;
  logic          vbl;
  logic          wr_en;
  logic [8:0]    wr_x;
  logic [DW-1:0] wr_data;
  logic          line_start;
  logic [8:0]    render_line;
  logic          init_done;
  logic [DW-1:0] pix;
  logic          pix_valid;

  modport master (
    output hc, vc, vbl, wr_en, wr_x, wr_data,
    input  line_start, render_line, init_done, pix, pix_valid
  );

  modport slave (
    input  hc, vc, vbl, wr_en, wr_x, wr_data,
    output line_start, render_line, init_done, pix, pix_valid
  );
endinterface
`default_nettype wire

// File: rtl/line_double_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_double_buffer
// Description : Double-buffered scanline buffer. The renderer fills the write
//               bank while the display bank is read out at hc; every displayed
//               pixel is cleared one clock after it is read. Banks swap at the
//               end of each line and line_start tells the renderer which line
//               to build next. After reset both banks are swept to CLEAR_VAL.
// Ports       : clk      - pixel clock
//               reset_n  - asynchronous active-low reset
//               bus      - line_double_buffer_if.slave (timing inputs,
//                          renderer write port, display outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module line_double_buffer #(
  parameter int            DW        = 8,
  parameter int            WIDTH     = 320,
  parameter int            HTOTAL    = 450,
  parameter int            VTOTAL    = 270,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  line_double_buffer_if.slave  bus
);

  localparam logic [8:0] c_width     = 9'(WIDTH);
  localparam logic [8:0] c_last_x    = 9'(WIDTH - 1);
  localparam logic [8:0] c_htotal    = 9'(HTOTAL);
  localparam logic [8:0] c_last_line = 9'(VTOTAL - 1);

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  // --------------------------------------------------------------------------
  // Control state machine
  // --------------------------------------------------------------------------
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [8:0] r_ic;
  logic       w_run;
  logic       w_init_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_init;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_init: if (r_ic == c_last_x) w_state_nxt = c_st_run;
      c_st_run:  w_state_nxt = c_st_run;
      default:   w_state_nxt = c_st_init;
    endcase
  end

  always_comb begin
    w_run     = 1'b0;
    w_init_wr = 1'b0;
    case (r_state)
      c_st_init: w_init_wr = 1'b1;
      c_st_run:  w_run     = 1'b1;
      default:   w_init_wr = 1'b1;
    endcase
  end

  // Sweep address; parks on the last address once the sweep is done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ic <= '0;
    end else if (w_init_wr && r_ic != c_last_x) begin
      r_ic <= r_ic + 9'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Bank selection, swap and renderer handshake
  // --------------------------------------------------------------------------
  logic       r_bank_sel;
  logic       r_line_start;
  logic [8:0] r_render_line;
  logic       w_swap;
  logic       w_rd_en;
  logic       w_wr_ok;
  logic       w_wr_bank;

  assign w_swap    = w_run && (bus.hc == c_htotal);
  assign w_rd_en   = w_run && (bus.hc < c_width);
  assign w_wr_ok   = w_run && bus.wr_en && (bus.wr_x < c_width);
  // Sampled before the swap takes effect, so a write in the swap cycle still
  // lands in the bank the renderer has been filling.
  assign w_wr_bank = ~r_bank_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank_sel    <= 1'b0;
      r_line_start  <= 1'b0;
      r_render_line <= '0;
    end else begin
      r_line_start <= w_swap;
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_render_line <= (bus.vc == c_last_line) ? 9'd0 : bus.vc + 9'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read stage: captures the bank and address of each read so the clear goes
  // back to exactly where the pixel came from.
  // --------------------------------------------------------------------------
  logic                r_rd_bank;
  logic                r_clr_en;
  logic [8:0]          r_clr_addr;
  logic                r_s1_active;
  logic [1:0][DW-1:0]  w_rd_data;
  logic [DW-1:0]       r_pix;
  logic                r_pix_valid;

  // --------------------------------------------------------------------------
  // Banks: one write port (sweep, clear or renderer) and one read port each.
  // Clear and renderer never target the same bank in normal raster timing;
  // the clear is given priority regardless.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic c_id = 1'(b);

    logic [DW-1:0] r_mem [WIDTH];
    logic [DW-1:0] r_rd;
    logic          w_we;
    logic [8:0]    w_wa;
    logic [DW-1:0] w_wd;

    always_comb begin
      w_we = 1'b0;
      w_wa = '0;
      w_wd = CLEAR_VAL;
      if (w_init_wr) begin
        w_we = 1'b1;
        w_wa = r_ic;
      end else if (r_clr_en && r_rd_bank == c_id) begin
        w_we = 1'b1;
        w_wa = r_clr_addr;
      end else if (w_wr_ok && w_wr_bank == c_id) begin
        w_we = 1'b1;
        w_wa = bus.wr_x;
        w_wd = bus.wr_data;
      end
    end

    always_ff @(posedge clk) begin
      if (w_we) begin
        r_mem[w_wa] <= w_wd;
      end
      if (w_rd_en && r_bank_sel == c_id) begin
        r_rd <= r_mem[bus.hc];
      end
    end

    assign w_rd_data[b] = r_rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_bank   <= 1'b0;
      r_clr_en    <= 1'b0;
      r_clr_addr  <= '0;
      r_s1_active <= 1'b0;
      r_pix       <= CLEAR_VAL;
      r_pix_valid <= 1'b0;
    end else begin
      r_rd_bank   <= r_bank_sel;
      r_clr_en    <= w_rd_en;
      r_clr_addr  <= bus.hc;
      // Reads during blanking still happen (and clear), but are not shown.
      r_s1_active <= w_rd_en && !bus.vbl;
      r_pix_valid <= r_s1_active;
      r_pix       <= r_s1_active ? w_rd_data[r_rd_bank] : CLEAR_VAL;
    end
  end

  assign bus.line_start  = r_line_start;
  assign bus.render_line = r_render_line;
  assign bus.init_done   = w_run;
  assign bus.pix         = r_pix;
  assign bus.pix_valid   = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_line_double_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_double_buffer
// Description : Self-checking bench for line_double_buffer. A behavioural
//               two-bank model predicts every output cycle; predictions are
//               queued and compared two clocks later. A table of renderer
//               writes and hand-written sequences cover last-write-wins,
//               dropped writes, swap-cycle writes, blanking and mid-line reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_double_buffer;

  localparam int DW = 8;
  localparam int W  = 320;
  localparam int HT = 450;
  localparam int VT = 270;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  line_double_buffer_if #(.DW(DW)) bus ();

  line_double_buffer #(
    .DW(DW), .WIDTH(W), .HTOTAL(HT), .VTOTAL(VT), .CLEAR_VAL(8'h00)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  typedef struct {
    logic [8:0] hc;
    logic       v;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       en;
    logic [8:0] x;
    logic [7:0] d;
    logic       chk;
    logic [7:0] exp;
  } wvec_t;

  wvec_t      tab [NV];
  exp_t       sb [$];
  logic [7:0] m_bank [2][W];
  logic       m_sel;
  logic       m_run;
  logic       m_ls;
  int         m_ic;
  logic [8:0] m_render;
  logic [7:0] seen [W];
  int         valid_cnt;
  int         nz_cnt;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: predict, advance the model, clock the DUT, compare.
  task automatic tick();
    exp_t e;
    exp_t o;
    logic [8:0] h;
    h = bus.hc;
    e.hc = h;
    e.v  = m_run && (h < 9'(W)) && !bus.vbl;
    e.d  = e.v ? m_bank[m_sel][h] : 8'h00;
    sb.push_back(e);
    m_ls = 1'b0;
    if (!m_run) begin
      m_bank[0][m_ic] = 8'h00;
      m_bank[1][m_ic] = 8'h00;
      if (m_ic == W - 1) m_run = 1'b1;
      else m_ic++;
    end else begin
      // displayed pixel is consumed (cleared) once read
      if (h < 9'(W)) m_bank[m_sel][h] = 8'h00;
      if (bus.wr_en && bus.wr_x < 9'(W)) m_bank[!m_sel][bus.wr_x] = bus.wr_data;
      if (h == 9'(HT)) begin
        m_ls     = 1'b1;
        m_sel    = !m_sel;
        m_render = (bus.vc == 9'(VT - 1)) ? 9'd0 : bus.vc + 9'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("init_done", 32'(bus.init_done), 32'(m_run));
    chk("line_start", 32'(bus.line_start), 32'(m_ls));
    chk("render_line", 32'(bus.render_line), 32'(m_render));
    if (sb.size() >= 2) begin
      o = sb.pop_front();
      chk("pix_valid", 32'(bus.pix_valid), 32'(o.v));
      chk("pix", 32'(bus.pix), 32'(o.d));
      if (bus.pix_valid === 1'b1 && o.hc < 9'(W)) begin
        valid_cnt++;
        seen[o.hc] = bus.pix;
        if (bus.pix != 8'h00) nz_cnt++;
      end
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pix", 32'(bus.pix), 32'h0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'h0);
    chk("rst_init_done", 32'(bus.init_done), 32'h0);
    chk("rst_line_start", 32'(bus.line_start), 32'h0);
    chk("rst_render_line", 32'(bus.render_line), 32'h0);
    sb.delete();
    m_run = 1'b0; m_ic = 0; m_sel = 1'b0; m_render = 9'd0; m_ls = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Renderer keeps strobing and hc visits HTOTAL; both must be ignored.
  task automatic run_init();
    for (int i = 0; i < W; i++) begin
      bus.hc      = (i % 2 == 1) ? 9'(HT) : 9'(i);
      bus.vc      = 9'(VT - 1);
      bus.vbl     = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_x    = 9'(i);
      bus.wr_data = 8'h5A;
      tick();
    end
    chk("init_done_after_W", 32'(bus.init_done), 32'h1);
  endtask

  // wmode: 0 none, 1 ramp x=hc, 2 table, 3 single write in the swap cycle
  task automatic run_line(input logic [8:0] v, input logic b, input int wmode, input int stop_hc);
    for (int i = 0; i < W; i++) seen[i] = 8'hFF;
    valid_cnt = 0;
    nz_cnt    = 0;
    for (int h = 0; h <= HT; h++) begin
      if (h == stop_hc) return;
      bus.hc = 9'(h); bus.vc = v; bus.vbl = b;
      bus.wr_en = 1'b0; bus.wr_x = 9'd0; bus.wr_data = 8'h00;
      case (wmode)
        1: if (h < W) begin bus.wr_en = 1'b1; bus.wr_x = 9'(h); bus.wr_data = 8'(h); end
        2: if (h < NV) begin bus.wr_en = tab[h].en; bus.wr_x = tab[h].x; bus.wr_data = tab[h].d; end
        3: if (h == HT) begin bus.wr_en = 1'b1; bus.wr_x = 9'd5; bus.wr_data = 8'hAA; end
        default: ;
      endcase
      tick();
    end
  endtask

  initial begin
    //          en    x        d      chk   exp
    tab[0]  = '{1'b1, 9'd3,   8'h11, 1'b0, 8'h00};
    tab[1]  = '{1'b1, 9'd7,   8'h22, 1'b1, 8'h22};
    tab[2]  = '{1'b1, 9'd3,   8'h33, 1'b1, 8'h33};
    tab[3]  = '{1'b1, 9'd320, 8'hFF, 1'b0, 8'h00};
    tab[4]  = '{1'b1, 9'd511, 8'hEE, 1'b0, 8'h00};
    tab[5]  = '{1'b1, 9'd0,   8'h44, 1'b1, 8'h44};
    tab[6]  = '{1'b1, 9'd319, 8'h55, 1'b1, 8'h55};
    tab[7]  = '{1'b1, 9'd100, 8'h66, 1'b0, 8'h00};
    tab[8]  = '{1'b1, 9'd100, 8'h77, 1'b1, 8'h77};
    tab[9]  = '{1'b1, 9'd200, 8'h88, 1'b1, 8'h88};
    tab[10] = '{1'b0, 9'd64,  8'h99, 1'b1, 8'h00};

    bus.hc = 9'd0; bus.vc = 9'd0; bus.vbl = 1'b0;
    bus.wr_en = 1'b0; bus.wr_x = 9'd0; bus.wr_data = 8'h00;
    for (int i = 0; i < W; i++) begin m_bank[0][i] = 8'h00; m_bank[1][i] = 8'h00; end

    apply_reset();
    run_init();

    // Ramp written on line 10 is shown on line 11.
    run_line(9'd9, 1'b0, 0, -1);
    run_line(9'd10, 1'b0, 1, -1);
    run_line(9'd11, 1'b0, 0, -1);
    chk("ramp_x0", 32'(seen[0]), 32'h00);
    chk("ramp_x1", 32'(seen[1]), 32'h01);
    chk("ramp_x127", 32'(seen[127]), 32'h7F);
    chk("ramp_x255", 32'(seen[255]), 32'hFF);
    chk("ramp_x319", 32'(seen[319]), 32'h3F);
    chk("ramp_valid_cnt", 32'(valid_cnt), 32'(W));

    // Same bank shown again two lines later: consumed by the earlier read.
    run_line(9'd12, 1'b0, 0, -1);
    run_line(9'd13, 1'b0, 0, -1);
    chk("cleared_nonzero", 32'(nz_cnt), 32'h0);
    chk("cleared_valid_cnt", 32'(valid_cnt), 32'(W));

    // Table writes, frame wrap, swap-cycle write.
    run_line(9'd268, 1'b0, 2, -1);
    run_line(9'(VT - 1), 1'b0, 3, -1);
    for (int i = 0; i < NV; i++) begin
      if (tab[i].chk) chk($sformatf("tab%0d_x%0d", i, tab[i].x), 32'(seen[tab[i].x]), 32'(tab[i].exp));
    end
    chk("wrap_line_start", 32'(bus.line_start), 32'h1);
    chk("wrap_render_line", 32'(bus.render_line), 32'h0);
    run_line(9'd0, 1'b0, 0, -1);
    chk("swap_write_x5", 32'(seen[5]), 32'hAA);
    chk("swap_write_others", 32'(nz_cnt), 32'h1);

    // Vertical blank hides the line.
    run_line(9'd1, 1'b0, 1, -1);
    run_line(9'd2, 1'b1, 0, -1);
    chk("vbl_valid_cnt", 32'(valid_cnt), 32'h0);

    // Reset in the middle of a displayed line.
    run_line(9'd3, 1'b0, 1, -1);
    run_line(9'd4, 1'b0, 0, 100);
    chk("pre_reset_x50", 32'(seen[50]), 32'h32);
    apply_reset();
    run_init();
    run_line(9'd5, 1'b0, 0, -1);
    chk("post_reset_nonzero_a", 32'(nz_cnt), 32'h0);
    chk("post_reset_valid_cnt", 32'(valid_cnt), 32'(W));
    run_line(9'd6, 1'b0, 0, -1);
    chk("post_reset_nonzero_b", 32'(nz_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
